// File: rtl/inst_axi_responder_pkg.sv
// rtl/inst_axi_responder_pkg.sv - shared AXI constants and types for the instruction-fetch responder
//
// Purpose: AXI encodings used on the read address channel, the outstanding
// counter width and the AR slot record. Imported by inst_axi_responder.
// Ports: none (package).

package inst_axi_responder_pkg;

  // AXI read-address encodings
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [3:0] AXI_CACHE_WBRA = 4'b1111;
  localparam logic [3:0] AXI_CACHE_DEV  = 4'b0000;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  // Outstanding counter width; DEPTH is limited to 1..15 so it never wraps.
  localparam int CNT_W = 4;

  // Contents of the registered AR slot.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  cache;
  } ar_slot_t;

  // Fetch-side cacheable bit to AXI cache attribute.
  function automatic logic [3:0] cache_attr(input logic cacheable);
    return cacheable ? AXI_CACHE_WBRA : AXI_CACHE_DEV;
  endfunction

endpackage

// File: rtl/inst_axi_responder.sv
// rtl/inst_axi_responder.sv - instruction-fetch request responder issuing single-beat AXI4 reads
//
// Purpose: accepts fetch requests (inst_req/inst_addr/inst_cache), answers with
// inst_addr_ok, issues one single-beat AXI read per request from a registered
// AR slot, and returns each word in order as inst_rdata/inst_data_ok.
// An outstanding counter (including the pending AR slot) bounds in-flight reads.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   inst_req/inst_cache/inst_addr  fetch request
//   inst_addr_ok                   request accepted this cycle (not gated by inst_req)
//   inst_data_ok/inst_rdata        returned word, one pulse per accepted request
//   inst_data_err                  qualifies inst_data_ok: SLVERR/DECERR
//   ar*                            AXI read address channel (master side)
//   r*                             AXI read data channel (master side, rready tied high)
//   err_unexp_o                    sticky: R beat with nothing outstanding
//   perfcnt_inst_wait              cycles with inst_req && !inst_addr_ok (wraps)

module inst_axi_responder
  import inst_axi_responder_pkg::*;
#(
  parameter int         DEPTH  = 4,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_cache,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arcache,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        err_unexp_o,
  output logic [31:0] perfcnt_inst_wait
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_arvalid;
  ar_slot_t         r_ar;
  logic [CNT_W-1:0] r_cnt;
  logic             r_data_ok;
  logic             r_data_err;
  logic [31:0]      r_rdata;
  logic             r_err_unexp;
  logic [31:0]      r_perf;

  logic w_addr_ok;
  logic w_accept;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_r_expected;
  logic w_cnt_dec;
  logic w_unused;

  // The slot can take a new request when empty or when it drains this cycle.
  assign w_addr_ok    = (!r_arvalid || arready) && (r_cnt < DEPTH_C);
  assign w_accept     = inst_req && w_addr_ok;
  assign w_ar_hs      = r_arvalid && arready;
  assign w_r_hs       = rvalid;                 // rready is always 1
  assign w_r_expected = w_r_hs && (r_cnt != '0);
  assign w_cnt_dec    = w_r_expected && rlast;

  // All reads share one ID and return in order, so rid carries no information.
  assign w_unused = ^{rid, rresp[0]};

  // AR slot: reload wins over the handshake clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arvalid <= 1'b0;
      r_ar      <= '0;
    end else if (w_accept) begin
      r_arvalid  <= 1'b1;
      r_ar.addr  <= inst_addr;
      r_ar.cache <= cache_attr(inst_cache);
    end else if (w_ar_hs) begin
      r_arvalid <= 1'b0;
    end
  end

  // Outstanding count: simultaneous accept and completing beat cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      case ({w_accept, w_cnt_dec})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Response register: beats with nothing outstanding are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_ok  <= 1'b0;
      r_data_err <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_data_ok  <= w_r_expected;
      r_data_err <= w_r_expected && rresp[1];
      if (w_r_expected) begin
        r_rdata <= rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_unexp <= 1'b0;
    end else if (w_r_hs && (r_cnt == '0)) begin
      r_err_unexp <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf <= '0;
    end else if (inst_req && !w_addr_ok) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign inst_addr_ok      = w_addr_ok;
  assign inst_data_ok      = r_data_ok;
  assign inst_data_err     = r_data_err;
  assign inst_rdata        = r_rdata;
  assign arid              = AXI_ID;
  assign araddr            = r_ar.addr;
  assign arlen             = AXI_LEN_SINGLE;
  assign arsize            = AXI_SIZE_4B;
  assign arburst           = AXI_BURST_INCR;
  assign arcache           = r_ar.cache;
  assign arvalid           = r_arvalid;
  assign rready            = 1'b1;
  assign err_unexp_o       = r_err_unexp;
  assign perfcnt_inst_wait = r_perf;

endmodule

// File: tb/tb_inst_axi_responder.sv
// tb/tb_inst_axi_responder.sv - self-checking bench for inst_axi_responder

module tb_inst_axi_responder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_cache;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok, inst_data_err;
  logic [31:0] inst_rdata;
  logic [3:0]  arid, arcache;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        err_unexp_o;
  logic [31:0] perfcnt_inst_wait;

  always #5 clk = ~clk;

  inst_axi_responder #(.DEPTH(DEPTH), .AXI_ID(4'd0)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata), .inst_data_err(inst_data_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arcache(arcache), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .err_unexp_o(err_unexp_o),
    .perfcnt_inst_wait(perfcnt_inst_wait)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: requests waiting for AR handshake, requests waiting for R,
  // and the number of accepted-but-unanswered requests.
  typedef struct {
    logic [31:0] a;
    logic        c;
  } req_t;

  req_t        q_ar[$];
  req_t        q_r[$];
  int          n_out;
  logic        exp_dok, exp_derr, exp_unexp;
  logic [31:0] exp_rdata, exp_perf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_ar.delete();
    q_r.delete();
    n_out     = 0;
    exp_dok   = 1'b0;
    exp_derr  = 1'b0;
    exp_unexp = 1'b0;
    exp_rdata = '0;
    exp_perf  = '0;
  endtask

  task automatic drive(input logic rq, input logic [31:0] ad, input logic ca,
                       input logic ar, input logic rv, input logic [31:0] rd,
                       input logic [1:0] rr);
    inst_req   = rq;
    inst_addr  = ad;
    inst_cache = ca;
    arready    = ar;
    rvalid     = rv;
    rdata      = rd;
    rresp      = rr;
    rlast      = 1'b1;
    rid        = 4'($urandom_range(0, 15));
  endtask

  // One clock cycle: inputs were set after a falling edge; check the accept
  // decision, advance the model, then check registered outputs after the edge.
  task automatic step();
    logic exp_ok;
    req_t it;
    #1;
    exp_ok = (q_ar.size() == 0 || arready) && (n_out < DEPTH);
    chk("addr_ok", {31'd0, inst_addr_ok}, {31'd0, exp_ok});
    if (inst_req && !exp_ok) exp_perf = exp_perf + 32'd1;
    exp_dok = 1'b0;
    if (rvalid) begin
      if (n_out != 0) begin
        exp_dok   = 1'b1;
        exp_rdata = rdata;
        exp_derr  = rresp[1];
        n_out--;
        if (q_r.size() > 0) void'(q_r.pop_front());
      end else begin
        exp_unexp = 1'b1;
      end
    end
    if (q_ar.size() > 0 && arready) q_r.push_back(q_ar.pop_front());
    if (inst_req && exp_ok) begin
      it.a = inst_addr;
      it.c = inst_cache;
      q_ar.push_back(it);
      n_out++;
    end
    @(posedge clk);
    #1;
    chk("arvalid", {31'd0, arvalid}, {31'd0, (q_ar.size() > 0)});
    if (q_ar.size() > 0) begin
      chk("araddr", araddr, q_ar[0].a);
      chk("arcache", {28'd0, arcache}, q_ar[0].c ? 32'hF : 32'h0);
    end
    chk("data_ok", {31'd0, inst_data_ok}, {31'd0, exp_dok});
    if (exp_dok) chk("data_err", {31'd0, inst_data_err}, {31'd0, exp_derr});
    chk("rdata", inst_rdata, exp_rdata);
    chk("err_unexp", {31'd0, err_unexp_o}, {31'd0, exp_unexp});
    chk("perfcnt", perfcnt_inst_wait, exp_perf);
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (20) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, (q_r.size() > 0), $urandom, 2'($urandom_range(0, 3)));
      step();
    end
  endtask

  initial begin
    int          nacc;
    logic [31:0] p0;

    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arcache", {28'd0, arcache}, 32'd0);
    chk("rst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("rst_data_err", {31'd0, inst_data_err}, 32'd0);
    chk("rst_rdata", inst_rdata, 32'd0);
    chk("rst_err_unexp", {31'd0, err_unexp_o}, 32'd0);
    chk("rst_perf", perfcnt_inst_wait, 32'd0);
    chk("rst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("arlen", {24'd0, arlen}, 32'd0);
    chk("arsize", {29'd0, arsize}, 32'd2);
    chk("arburst", {30'd0, arburst}, 32'd1);
    chk("arid", {28'd0, arid}, 32'd0);
    chk("rready", {31'd0, rready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Single request, minimum latency.
    drive(1'b1, 32'h1FC0_0000, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
    step();
    chk("t1_arvalid", {31'd0, arvalid}, 32'd1);
    chk("t1_araddr", araddr, 32'h1FC0_0000);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h3C08_BFC0, 2'b00);
    step();
    chk("t1_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t1_rdata", inst_rdata, 32'h3C08_BFC0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
    step();

    // Fill to DEPTH with R held off, then release four beats.
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
      #1;
      nacc += int'(inst_addr_ok);
      step();
    end
    chk("full_accepts", 32'(nacc), 32'd4);
    drive(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
    #1;
    chk("full_ok_low", {31'd0, inst_addr_ok}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hD000_0000 + 32'(i), 2'b00);
      step();
      chk("full_beat_ok", {31'd0, inst_data_ok}, 32'd1);
      chk("full_beat_data", inst_rdata, 32'hD000_0000 + 32'(i));
      if (i == 0 || i == 3) chk("full_reopen", {31'd0, inst_addr_ok}, 32'd1);
    end

    // AR stall: slot held stable, waits counted.
    drive(1'b1, 32'h8000_1000, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
    step();
    p0 = exp_perf;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h9000_0000 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
      step();
      chk("stall_araddr", araddr, 32'h8000_1000);
      chk("stall_arcache", {28'd0, arcache}, 32'hF);
    end
    chk("stall_perf", perfcnt_inst_wait, p0 + 32'd5);
    drain();

    // Accept and completing beat in the same cycle with two outstanding.
    drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
    step();
    drive(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
    step();
    drive(1'b1, 32'h108, 1'b0, 1'b1, 1'b1, 32'hCAFE_0000, 2'b00);
    step();
    chk("same_data_ok", {31'd0, inst_data_ok}, 32'd1);
    nacc = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h10C + 32'(i * 4), 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
      #1;
      nacc += int'(inst_addr_ok);
      step();
    end
    chk("same_cnt_room", 32'(nacc), 32'd2);
    drain();

    // Error response.
    drive(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1234, 2'b10);
    step();
    chk("err_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("err_data_err", {31'd0, inst_data_err}, 32'd1);

    // Randomized traffic against a legal in-order slave.
    repeat (400) begin
      drive(($urandom_range(0, 9) < 7), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 6), (q_r.size() > 0) && ($urandom_range(0, 1) == 1),
            $urandom, 2'($urandom_range(0, 3)));
      step();
    end
    drain();

    // Asynchronous reset with three outstanding and a data pulse in flight.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hBEEF, 2'b00);
    step();
    chk("rst_pre_dok", {31'd0, inst_data_ok}, 32'd1);
    chk("rst_pre_arvalid", {31'd0, arvalid}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("arst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("arst_rdata", inst_rdata, 32'd0);
    chk("arst_perf", perfcnt_inst_wait, 32'd0);
    chk("arst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Stale beat after reset is unexpected and sticky.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h5555_5555, 2'b00);
    step();
    chk("unexp_flag", {31'd0, err_unexp_o}, 32'd1);
    chk("unexp_no_dok", {31'd0, inst_data_ok}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
    step();
    chk("unexp_sticky", {31'd0, err_unexp_o}, 32'd1);

    // Counter really cleared: a full DEPTH of accepts is available again.
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
      #1;
      nacc += int'(inst_addr_ok);
      step();
    end
    chk("rst_cnt_clear", 32'(nacc), 32'd4);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
